// File: rtl/chip8_draw_ctrl.sv
// chip8_draw_ctrl: owns every write to the 1-bit CHIP-8 framebuffer.
// Runs CLS (clear screen) and DXYN (XOR an N-row sprite fetched from memory).
// Optional build macro: DRAW_CLIP_EN. When it is defined, pixels past the right
// or bottom edge are suppressed. When it is undefined, they wrap around both axes.
module chip8_draw_ctrl #(
  parameter int ADDR_W = 12,
  parameter int FB_W   = 64,
  parameter int FB_H   = 32
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic              cls,
  input  logic [7:0]        x_in,
  input  logic [7:0]        y_in,
  input  logic [3:0]        n_in,
  input  logic [ADDR_W-1:0] i_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic [5:0]        fb_x,
  output logic [4:0]        fb_y,
  input  logic              fb_rdata,
  output logic              fb_we,
  output logic              fb_wdata,
  output logic              busy,
  output logic              done,
  output logic              collision
);

  typedef enum logic [2:0] {IDLE, CLR, FETCH, WAIT, PIX, DONE} state_t;

  state_t            state, state_nxt;
  logic [5:0]        x0;
  logic [4:0]        y0;
  logic [3:0]        n;
  logic [ADDR_W-1:0] ibase;
  logic [3:0]        r;
  logic [2:0]        c;
  logic [7:0]        shreg;
  logic [5:0]        cx;
  logic [4:0]        cy;

  logic [6:0]        sum_x;
  logic [5:0]        sum_y;
  logic              x_off, y_off;
  logic [5:0]        px;
  logic [4:0]        py;
  logic              bit_on, pix_en;
  logic              clr_last, row_last;

  // Sprite pixel coordinate, edge detection and write qualification
  always_comb begin
    sum_x    = {1'b0, x0} + {4'b0, c};
    sum_y    = {1'b0, y0} + {2'b0, r};
    x_off    = sum_x >= 7'(FB_W);
    y_off    = sum_y >= 6'(FB_H);
    px       = x_off ? 6'(sum_x - 7'(FB_W)) : sum_x[5:0];
    py       = y_off ? 5'(sum_y - 6'(FB_H)) : sum_y[4:0];
    bit_on   = shreg[3'd7 - c];
`ifdef DRAW_CLIP_EN
    pix_en   = bit_on & ~x_off & ~y_off;
`else
    pix_en   = bit_on;
`endif
    clr_last = (cx == 6'(FB_W - 1)) && (cy == 5'(FB_H - 1));
    row_last = (r + 4'd1) == n;
  end

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) begin
               if (cls)             state_nxt = CLR;
               else if (n_in == '0) state_nxt = DONE;
               else                 state_nxt = FETCH;
             end
      CLR:   if (clr_last) state_nxt = DONE;
      FETCH: state_nxt = WAIT;
      WAIT:  state_nxt = PIX;
      PIX:   if (c == 3'd7) state_nxt = row_last ? DONE : FETCH;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch, counters, sprite shift register and sticky collision flag
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      x0        <= '0;
      y0        <= '0;
      n         <= '0;
      ibase     <= '0;
      r         <= '0;
      c         <= '0;
      shreg     <= '0;
      cx        <= '0;
      cy        <= '0;
      collision <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          x0        <= 6'(x_in % 8'(FB_W));
          y0        <= 5'(y_in % 8'(FB_H));
          n         <= n_in;
          ibase     <= i_in;
          r         <= '0;
          c         <= '0;
          cx        <= '0;
          cy        <= '0;
          collision <= 1'b0;
        end
        CLR: begin
          if (cx == 6'(FB_W - 1)) begin
            cx <= '0;
            cy <= cy + 5'd1;
          end else begin
            cx <= cx + 6'd1;
          end
        end
        WAIT: begin
          shreg <= mem_rdata;
          c     <= '0;
        end
        PIX: begin
          c <= c + 3'd1;
          if (c == 3'd7) r <= r + 4'd1;
          if (pix_en && fb_rdata) collision <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Output decode from the current state
  always_comb begin
    mem_addr = '0;
    mem_rd   = 1'b0;
    fb_x     = '0;
    fb_y     = '0;
    fb_we    = 1'b0;
    fb_wdata = 1'b0;
    busy     = state != IDLE;
    done     = state == DONE;
    case (state)
      CLR: begin
        fb_x  = cx;
        fb_y  = cy;
        fb_we = 1'b1;
      end
      FETCH: begin
        mem_rd   = 1'b1;
        mem_addr = ibase + ADDR_W'(r);
      end
      PIX: begin
        fb_x     = px;
        fb_y     = py;
        fb_we    = pix_en;
        fb_wdata = pix_en & ~fb_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_chip8_draw_ctrl.sv
// Self-checking bench for chip8_draw_ctrl: directed scenarios plus random
// commands, checked cycle by cycle against a behavioural model.
module tb_chip8_draw_ctrl;

`ifdef DRAW_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        start = 1'b0;
  logic        cls = 1'b0;
  logic [7:0]  x_in = '0;
  logic [7:0]  y_in = '0;
  logic [3:0]  n_in = '0;
  logic [11:0] i_in = '0;
  logic [11:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata = '0;
  logic [5:0]  fb_x;
  logic [4:0]  fb_y;
  logic        fb_rdata;
  logic        fb_we, fb_wdata, busy, done, collision;

  chip8_draw_ctrl #(.ADDR_W(12), .FB_W(64), .FB_H(32)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .cls(cls),
    .x_in(x_in), .y_in(y_in), .n_in(n_in), .i_in(i_in),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .fb_x(fb_x), .fb_y(fb_y), .fb_rdata(fb_rdata), .fb_we(fb_we),
    .fb_wdata(fb_wdata), .busy(busy), .done(done), .collision(collision)
  );

  always #5 Clk = ~Clk;

  // Bench-side main memory and framebuffer
  logic [7:0] mem [4096];
  bit         fbm [32][64];
  bit         mfb [32][64];
  bit         fill_req = 1'b0;
  int         fill_kind = 0;

  always @(posedge Clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
    if (fill_req) begin
      for (int yy = 0; yy < 32; yy++)
        for (int xx = 0; xx < 64; xx++)
          fbm[yy][xx] <= (fill_kind == 1) ? 1'b1 : bit'($urandom_range(0, 1));
    end else if (fb_we) begin
      fbm[fb_y][fb_x] <= fb_wdata;
    end
  end
  assign fb_rdata = fbm[fb_y][fb_x];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Expected outputs for one cycle
  typedef struct {
    bit busy;
    bit done;
    bit rd;
    int addr;
    bit we;
    bit wd;
    bit xy;
    int x;
    int y;
    bit coll;
  } ent_t;

  ent_t q[$];
  bit   mcoll = 1'b0;
  bit   chk_en = 1'b0;

  // Model: expand one command into its cycle-by-cycle expected outputs
  task automatic build(input bit ccls, input int x, input int y, input int n, input int i);
    ent_t e;
    bit   scr [32][64];
    bit   cc;
    int   x0, y0, sx, sy, px, py, a;
    bit   on;
    logic [7:0] b;
    scr = mfb;
    e = '{default: 0};
    e.coll = mcoll;
    q.push_back(e);
    x0 = x % 64;
    y0 = y % 32;
    cc = 1'b0;
    if (ccls) begin
      for (int yy = 0; yy < 32; yy++)
        for (int xx = 0; xx < 64; xx++) begin
          e = '{default: 0};
          e.busy = 1; e.we = 1; e.wd = 0; e.xy = 1; e.x = xx; e.y = yy;
          q.push_back(e);
        end
    end else begin
      for (int r = 0; r < n; r++) begin
        a = (i + r) % 4096;
        e = '{default: 0};
        e.busy = 1; e.rd = 1; e.addr = a; e.coll = cc;
        q.push_back(e);
        e = '{default: 0};
        e.busy = 1; e.coll = cc;
        q.push_back(e);
        b = mem[a];
        for (int col = 0; col < 8; col++) begin
          sx = x0 + col;
          sy = y0 + r;
          px = sx % 64;
          py = sy % 32;
          on = b[7 - col] && !(CLIP && (sx >= 64 || sy >= 32));
          e = '{default: 0};
          e.busy = 1; e.xy = 1; e.x = px; e.y = py; e.coll = cc;
          if (on) begin
            e.we = 1;
            e.wd = !scr[py][px];
            if (scr[py][px]) cc = 1'b1;
            scr[py][px] = !scr[py][px];
          end
          q.push_back(e);
        end
      end
    end
    e = '{default: 0};
    e.busy = 1; e.done = 1; e.coll = cc;
    q.push_back(e);
  endtask

  // Compare process: every cycle against the model (idle when queue empty)
  always @(negedge Clk) begin
    ent_t e;
    if (chk_en) begin
      if (q.size() > 0) e = q.pop_front();
      else begin
        e = '{default: 0};
        e.coll = mcoll;
      end
      chk("busy", busy, e.busy);
      chk("done", done, e.done);
      chk("mem_rd", mem_rd, e.rd);
      if (e.rd) chk("mem_addr", mem_addr, e.addr);
      chk("fb_we", fb_we, e.we);
      if (e.we) chk("fb_wdata", fb_wdata, e.wd);
      if (e.xy) begin
        chk("fb_x", fb_x, e.x);
        chk("fb_y", fb_y, e.y);
      end
      chk("collision", collision, e.coll);
      if (e.we) mfb[e.y][e.x] = e.wd;
      mcoll = e.coll;
    end
  end

  int rd_q[$];
  int we_cnt;

  task automatic issue(input bit ccls, input int x, input int y, input int n, input int i);
    @(posedge Clk); #1;
    cls = ccls; x_in = 8'(x); y_in = 8'(y); n_in = 4'(n); i_in = 12'(i);
    start = 1'b1;
    build(ccls, x, y, n, i);
    @(posedge Clk); #1;
    start = 1'b0;
  endtask

  task automatic run_cmd(input bit ccls, input int x, input int y, input int n, input int i,
                         input bit noise, output int lat);
    issue(ccls, x, y, n, i);
    lat = 0;
    rd_q.delete();
    we_cnt = 0;
    forever begin
      @(negedge Clk);
      lat++;
      if (mem_rd) rd_q.push_back(int'(mem_addr));
      if (fb_we) we_cnt++;
      if (done) break;
      if (lat > 3000) begin
        chk("done_timeout", lat, -1);
        break;
      end
      if (noise && $urandom_range(0, 3) == 0) begin
        start = 1'b1;
        cls = 1'($urandom);
        x_in = 8'($urandom);
        n_in = 4'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic fill_fb(input int kind);
    @(posedge Clk); #1;
    fill_kind = kind;
    fill_req = 1'b1;
    @(posedge Clk); #1;
    fill_req = 1'b0;
    mfb = fbm;
  endtask

  task automatic check_image(input string nm);
    int mism = 0;
    for (int yy = 0; yy < 32; yy++)
      for (int xx = 0; xx < 64; xx++)
        if (fbm[yy][xx] != mfb[yy][xx]) mism++;
    chk(nm, mism, 0);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_mem_addr"}, mem_addr, 0);
    chk({nm, "_mem_rd"}, mem_rd, 0);
    chk({nm, "_fb_x"}, fb_x, 0);
    chk({nm, "_fb_y"}, fb_y, 0);
    chk({nm, "_fb_we"}, fb_we, 0);
    chk({nm, "_fb_wdata"}, fb_wdata, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_collision"}, collision, 0);
  endtask

  initial begin
    int lat, exp_lat, zeros, x, y, n, i;
    bit c;
    for (int k = 0; k < 4096; k++) mem[k] = 8'($urandom);

    #23;
    check_reset_outputs("reset");
    @(negedge Clk); Reset_n = 1'b1;
    @(negedge Clk); chk_en = 1'b1;

    // CLS over an all-ones screen
    fill_fb(1);
    run_cmd(1'b1, 0, 0, 0, 0, 1'b0, lat);
    chk("cls_latency", lat, 2049);
    chk("cls_writes", we_cnt, 2048);
    chk("cls_collision", collision, 0);
    zeros = 0;
    for (int yy = 0; yy < 32; yy++)
      for (int xx = 0; xx < 64; xx++)
        if (fbm[yy][xx] == 1'b0) zeros++;
    chk("cls_zero_pixels", zeros, 2048);

    // First draw of 0xF0 at (0,0)
    mem[12'h200] = 8'hF0;
    run_cmd(1'b0, 0, 0, 1, 12'h200, 1'b0, lat);
    chk("draw1_latency", lat, 11);
    chk("draw1_rd_count", rd_q.size(), 1);
    if (rd_q.size() > 0) chk("draw1_rd_addr", rd_q[0], 12'h200);
    chk("draw1_px0", fbm[0][0], 1);
    chk("draw1_px3", fbm[0][3], 1);
    chk("draw1_px4", fbm[0][4], 0);
    chk("draw1_px7", fbm[0][7], 0);
    chk("draw1_collision", collision, 0);

    // Identical draw erases and collides
    run_cmd(1'b0, 0, 0, 1, 12'h200, 1'b0, lat);
    chk("draw2_px0", fbm[0][0], 0);
    chk("draw2_px3", fbm[0][3], 0);
    chk("draw2_collision", collision, 1);

    // Corner draw: wrap or clip
    mem[12'h300] = 8'hFF;
    mem[12'h301] = 8'hFF;
    run_cmd(1'b0, 62, 31, 2, 12'h300, 1'b0, lat);
    chk("corner_latency", lat, 21);
    chk("corner_62_31", fbm[31][62], 1);
    chk("corner_63_31", fbm[31][63], 1);
    chk("corner_0_31", fbm[31][0], CLIP ? 0 : 1);
    chk("corner_5_31", fbm[31][5], CLIP ? 0 : 1);
    chk("corner_6_31", fbm[31][6], 0);
    chk("corner_62_0", fbm[0][62], CLIP ? 0 : 1);
    chk("corner_5_0", fbm[0][5], CLIP ? 0 : 1);
    chk("corner_writes", we_cnt, CLIP ? 2 : 16);

    // Out-of-range coordinates; n=0 then n=1
    run_cmd(1'b0, 70, 40, 0, 12'h400, 1'b0, lat);
    chk("n0_latency", lat, 1);
    chk("n0_rd_count", rd_q.size(), 0);
    chk("n0_writes", we_cnt, 0);
    mem[12'h400] = 8'h80;
    run_cmd(1'b0, 70, 40, 1, 12'h400, 1'b0, lat);
    chk("mod_px_6_8", fbm[8][6], 1);
    chk("mod_px_7_8", fbm[8][7], 0);

    // Address wrap at the top of memory
    run_cmd(1'b0, 20, 3, 2, 12'hFFF, 1'b0, lat);
    chk("wrap_rd_count", rd_q.size(), 2);
    if (rd_q.size() == 2) begin
      chk("wrap_addr0", rd_q[0], 12'hFFF);
      chk("wrap_addr1", rd_q[1], 12'h000);
    end
    check_image("image_directed");

    // Reset during PIX
    mem[12'h500] = 8'hFF;
    issue(1'b0, 10, 10, 3, 12'h500);
    repeat (4) @(posedge Clk);
    #1;
    chk_en = 1'b0;
    Reset_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (3) begin
      @(negedge Clk);
      chk("abort_no_we", fb_we, 0);
      chk("abort_no_done", done, 0);
    end
    q.delete();
    mcoll = 1'b0;
    #2 Reset_n = 1'b1;
    @(negedge Clk); chk_en = 1'b1;
    repeat (3) @(negedge Clk);
    check_image("image_after_abort");

    // Random commands with start noise while busy
    fill_fb(2);
    for (int k = 0; k < 25; k++) begin
      c = ($urandom_range(0, 9) == 0);
      x = $urandom_range(0, 255);
      y = $urandom_range(0, 255);
      n = $urandom_range(0, 15);
      i = ($urandom_range(0, 3) == 0) ? 12'hFF0 + $urandom_range(0, 15) : $urandom_range(0, 4095);
      exp_lat = c ? 2049 : (n == 0 ? 1 : 10 * n + 1);
      run_cmd(c, x, y, n, i, 1'b1, lat);
      chk("rand_latency", lat, exp_lat);
      repeat ($urandom_range(0, 3)) @(negedge Clk);
    end
    check_image("image_random");

    @(negedge Clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/chip8_draw_ctrl.md
Name: chip8_draw_ctrl

Overview:
- Sequencer that owns all writes to the 64x32 one-bit CHIP-8 framebuffer.
- Executes the CLS command (00E0, clear screen) and the DXYN command (draw an N-byte sprite at X,Y).
- For DXYN it fetches sprite rows from main memory, XORs them into the framebuffer pixel by pixel, and reports the VF collision flag.
- Sits between the CPU execute stage, the memory read port and the framebuffer that feeds the VGA colour path.

Parameters:
- ADDR_W, 12, memory address width.
- FB_W, 64, framebuffer width in pixels.
- FB_H, 32, framebuffer height in pixels.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- cls  in  1  1 = clear screen, 0 = draw sprite; sampled with start.
- x_in  in  8  sprite X (VX); sampled with start.
- y_in  in  8  sprite Y (VY); sampled with start.
- n_in  in  4  sprite height in rows; sampled with start.
- i_in  in  ADDR_W  sprite base address (I); sampled with start.
- mem_addr  out  ADDR_W  memory read address.
- mem_rd  out  1  memory read request.
- mem_rdata  in  8  read data, valid exactly 1 cycle after mem_rd.
- fb_x  out  6  framebuffer pixel column.
- fb_y  out  5  framebuffer pixel row.
- fb_rdata  in  1  current pixel at (fb_x,fb_y), combinational read.
- fb_we  out  1  pixel write enable.
- fb_wdata  out  1  pixel write value.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- collision  out  1  VF result of the last draw.

Behaviour:
- Reset (asynchronous, Reset_n=0): state=IDLE. All outputs 0: mem_addr, mem_rd, fb_x, fb_y, fb_we, fb_wdata, busy, done, collision. Internal row/column counters and shift register also cleared.
- Reset asserted mid-command aborts the command immediately. No further fb_we occurs and no done pulse is produced.
- States: IDLE, CLR, FETCH, WAIT, PIX, DONE.
- IDLE:
  - start=1 latches all command inputs.
  - x0 = x_in mod 64, y0 = y_in mod 32.
  - Clears collision.
  - Next state: CLR if cls=1; DONE if n_in=0; else FETCH with row r=0.
  - start is ignored in every other state; no queuing.
- busy = 1 in every state except IDLE, and drops in the cycle after DONE.
- CLR:
  - One pixel per cycle, row-major from (0,0) to (63,31).
  - fb_we=1, fb_wdata=0.
  - Exactly 2048 cycles, then DONE.
- FETCH:
  - mem_rd=1, mem_addr = (i + r) mod 2^ADDR_W; address wraps at 0xFFF.
  - Next state: WAIT.
- WAIT:
  - mem_rdata is captured into an 8-bit shift register.
  - Column c=0. Next state: PIX.
- PIX, 8 cycles per row, MSB first:
  - fb_x = (x0 + c) mod 64, fb_y = (y0 + r) mod 32.
  - Sprite bit b = shreg[7-c].
  - b=1: fb_we=1, fb_wdata = ~fb_rdata; if fb_rdata=1, set collision (sticky for the command).
  - b=0: fb_we=0.
  - After c=7: r increments. If r == n, next state is DONE; else FETCH.
- DONE: done=1 for one cycle, next state IDLE. collision holds until the next accepted start.
- Latency from the start cycle to the done cycle:
  - CLS: 2049 cycles.
  - Draw: 10*n + 1 cycles.
  - n=0: 1 cycle.
- mem_rd is high only in FETCH. fb_we is high only in CLR and in PIX with b=1.

Optional Feature:
- Macro: DRAW_CLIP_EN.
- Defined: pixels with x0 + c >= 64 or y0 + r >= 32 are suppressed (fb_we=0, no collision contribution). Cycle count is unchanged. The start coordinate is still taken mod 64/32.
- Undefined: off-screen pixels wrap around both axes, as described in Behaviour.

Test Plan:
- CLS on a framebuffer that is all ones -> 2048 writes of 0, done 2049 cycles after start, collision=0, framebuffer all zero.
- Empty framebuffer; draw x=0, y=0, n=1, mem[I]=0xF0 -> pixels (0..3,0)=1 and (4..7,0)=0; mem_rd once at address I; done at cycle 11; collision=0.
- Repeat the identical draw -> those pixels return to 0, collision=1.
- Draw x=62, y=31, n=2, bytes 0xFF,0xFF:
  - Without DRAW_CLIP_EN: pixels at x 62,63,0..5 on rows 31 and 0 are set.
  - With DRAW_CLIP_EN: only (62,31) and (63,31) are set.
- x_in=70, y_in=40 -> treated as (6,8). n=0 -> done 1 cycle after start, no fb_we, no mem_rd.
- start pulsed while busy -> ignored.
- Reset_n pulsed low during PIX -> all outputs 0 immediately, state IDLE, no done pulse.
- i_in=0xFFF with n=2 -> mem_addr sequence 0xFFF then 0x000.
